// File: rtl/collision_pkg.sv
// Shared types and constants for the map-collision sequencer and its corner address generator.
package collision_pkg;

  localparam int unsigned MAP_W_DEF       = 256;
  localparam int unsigned MAP_H_DEF       = 176;
  localparam int unsigned SPRITE_SIZE_DEF = 16;
  localparam int unsigned MOVE_PX         = 1;
  localparam int unsigned ADDR_W          = 17;

  typedef enum logic [2:0] {
    DirNoAction = 3'd0,
    DirAttack   = 3'd1,
    DirUp       = 3'd2,
    DirDown     = 3'd3,
    DirLeft     = 3'd4,
    DirRight    = 3'd5
  } dir_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StDrain,
    StNext,
    StFin
  } state_e;

  function automatic logic is_move(logic [2:0] dir);
    return (dir == DirUp) || (dir == DirDown) || (dir == DirLeft) || (dir == DirRight);
  endfunction

endpackage

// File: rtl/collision_sequencer_if.sv
// Game-control and level-map ROM signals of the collision sequencer.
interface collision_sequencer_if
  import collision_pkg::*;
#(
  parameter int unsigned NUM_ENT = 2
);
  logic                   start;
  logic [9*NUM_ENT-1:0]   ent_x;
  logic [8*NUM_ENT-1:0]   ent_y;
  logic [3*NUM_ENT-1:0]   ent_dir;
  logic [ADDR_W-1:0]      rom_address;
  logic                   rom_q;
  logic [NUM_ENT-1:0]     map_collision;
  logic [NUM_ENT-1:0]     overlap;
  logic                   busy;
  logic                   done;

  // Environment side: game control plus the ROM data return.
  modport master (
    output start, ent_x, ent_y, ent_dir, rom_q,
    input  rom_address, map_collision, overlap, busy, done
  );

  modport slave (
    input  start, ent_x, ent_y, ent_dir, rom_q,
    output rom_address, map_collision, overlap, busy, done
  );
endinterface

// File: rtl/corner_addr_gen.sv
// Combinational next-position corner address for one sprite, plus the map-edge exception flag.
module corner_addr_gen
  import collision_pkg::*;
#(
  parameter int unsigned SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int unsigned MAP_W       = MAP_W_DEF,
  parameter int unsigned MAP_H       = MAP_H_DEF
) (
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [2:0]        dir,
  input  logic [1:0]        corner,
  output logic [ADDR_W-1:0] address,
  output logic              exception
);

  logic [8:0] nx;
  logic [7:0] ny;
  logic [8:0] cx;
  logic [7:0] cy;

  always_comb begin
    nx        = x;
    ny        = y;
    exception = 1'b0;
    case (dir)
      DirUp: begin
        exception = (y == '0);
        ny        = y - 8'(MOVE_PX);
      end
      DirDown: begin
        exception = (32'(y) + SPRITE_SIZE == MAP_H);
        ny        = y + 8'(MOVE_PX);
      end
      DirLeft: begin
        exception = (x == '0);
        nx        = x - 9'(MOVE_PX);
      end
      DirRight: begin
        exception = (32'(x) + SPRITE_SIZE == MAP_W);
        nx        = x + 9'(MOVE_PX);
      end
      default: ;
    endcase
    // corner[0] selects the right edge, corner[1] the bottom edge: TL, TR, BL, BR.
    cx      = nx + (corner[0] ? 9'(SPRITE_SIZE - 1) : 9'd0);
    cy      = ny + (corner[1] ? 8'(SPRITE_SIZE - 1) : 8'd0);
    address = ADDR_W'(cy) * ADDR_W'(MAP_W) + ADDR_W'(cx);
  end

endmodule

// File: rtl/collision_sequencer.sv
// Time-shares one level-map ROM to produce a per-entity map-collision flag after a start pulse.
// Optional ENTITY_OVERLAP_EN macro builds player/entity bounding-box overlap flags.
module collision_sequencer
  import collision_pkg::*;
#(
  parameter int unsigned NUM_ENT     = 2,
  parameter int unsigned SPRITE_SIZE = SPRITE_SIZE_DEF,
  parameter int unsigned MAP_W       = MAP_W_DEF,
  parameter int unsigned MAP_H       = MAP_H_DEF,
  parameter int unsigned ROM_LATENCY = 1
) (
  input logic                  clock,
  input logic                  reset,
  collision_sequencer_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;

  state_e                 state_q, state_d;
  logic [8:0]             x_q   [NUM_ENT];
  logic [7:0]             y_q   [NUM_ENT];
  logic [2:0]             dir_q [NUM_ENT];
  logic [IDX_W-1:0]       ent_q;
  logic [1:0]             corner_q;
  logic [1:0]             drain_q;
  logic                   res_q;
  logic [ROM_LATENCY-1:0] vld_q;
  logic [NUM_ENT-1:0]     pend_q, pend_next;
  logic [NUM_ENT-1:0]     mc_q, ov_q, ov_calc;
  logic [ADDR_W-1:0]      gen_addr;
  logic                   gen_exc;
  logic                   last_ent;

  corner_addr_gen #(
    .SPRITE_SIZE (SPRITE_SIZE),
    .MAP_W       (MAP_W),
    .MAP_H       (MAP_H)
  ) u_corner_addr_gen (
    .x         (x_q[ent_q]),
    .y         (y_q[ent_q]),
    .dir       (dir_q[ent_q]),
    .corner    (corner_q),
    .address   (gen_addr),
    .exception (gen_exc)
  );

  assign last_ent = (ent_q == IDX_W'(NUM_ENT - 1));

  always_comb begin
    pend_next        = pend_q;
    pend_next[ent_q] = res_q;
  end

`ifdef ENTITY_OVERLAP_EN
  logic [8:0] dx;
  logic [7:0] dy;
  always_comb begin
    ov_calc = '0;
    dx      = '0;
    dy      = '0;
    for (int e = 1; e < NUM_ENT; e++) begin
      dx = (x_q[0] >= x_q[e]) ? x_q[0] - x_q[e] : x_q[e] - x_q[0];
      dy = (y_q[0] >= y_q[e]) ? y_q[0] - y_q[e] : y_q[e] - y_q[0];
      ov_calc[e] = (32'(dx) < SPRITE_SIZE) && (32'(dy) < SPRITE_SIZE);
    end
  end
`else
  assign ov_calc = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad:  state_d = (!is_move(dir_q[ent_q]) || gen_exc) ? StNext : StIssue;
      StIssue: if (corner_q == 2'd3) state_d = StDrain;
      StDrain: if (drain_q == 2'(ROM_LATENCY - 1)) state_d = StNext;
      StNext:  state_d = last_ent ? StFin : StLoad;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ent_q    <= '0;
      corner_q <= '0;
      drain_q  <= '0;
      res_q    <= 1'b0;
      vld_q    <= '0;
      pend_q   <= '0;
      mc_q     <= '0;
      ov_q     <= '0;
      for (int e = 0; e < NUM_ENT; e++) begin
        x_q[e]   <= '0;
        y_q[e]   <= '0;
        dir_q[e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      // Tags each issued read so its rom_q sample is taken ROM_LATENCY cycles later.
      vld_q[0] <= (state_q == StIssue);
      for (int i = 1; i < ROM_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            for (int e = 0; e < NUM_ENT; e++) begin
              x_q[e]   <= bus.ent_x[9*e +: 9];
              y_q[e]   <= bus.ent_y[8*e +: 8];
              dir_q[e] <= bus.ent_dir[3*e +: 3];
            end
            ent_q  <= '0;
            pend_q <= '0;
          end
        end
        StLoad: begin
          res_q    <= gen_exc;
          corner_q <= '0;
          drain_q  <= '0;
        end
        StIssue: corner_q <= corner_q + 2'd1;
        StDrain: drain_q <= drain_q + 2'd1;
        StNext: begin
          pend_q <= pend_next;
          if (last_ent) begin
            mc_q <= pend_next;
            ov_q <= ov_calc;
          end else begin
            ent_q <= ent_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
      if (vld_q[ROM_LATENCY-1]) res_q <= res_q | ~bus.rom_q;
    end
  end

  assign bus.rom_address   = (state_q == StIssue) ? gen_addr : '0;
  assign bus.map_collision = mc_q;
  assign bus.overlap       = ov_q;
  assign bus.done          = (state_q == StFin);
  assign bus.busy          = (state_q != StIdle) && (state_q != StFin);

endmodule
